// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, LW/SW data-memory handshake with timeout,
// and MEM/WB register feeding write-back plus branch/jump redirect.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_exi,
    input  logic [5:0]  op_exi,
    input  logic [4:0]  Ri_exi,
    input  logic        ife_exi,
    input  logic [31:0] alu_exi,
    input  logic [31:0] addr_exi,
    output logic        stall_mem,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        valid_memo,
    output logic [5:0]  op_memo,
    output logic [4:0]  Ri_memo,
    output logic        wb_en_mem,
    output logic [31:0] wb_data_mem,
    output logic        br_taken_mem,
    output logic [31:0] br_target_mem,
    output logic        err_mem
);

    localparam logic [5:0] OpSw     = 6'b010000;
    localparam logic [5:0] OpLw     = 6'b010001;
    localparam logic [5:0] OpBeq    = 6'b100000;
    localparam logic [5:0] OpJmp    = 6'b100001;
    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e      st_q, st_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    // EX/MEM register
    logic        valid_q;
    logic [5:0]  op_q;
    logic [4:0]  ri_q;
    logic        ife_q;
    logic [31:0] alu_q;
    logic [31:0] addr_q;

    // MEM/WB register
    logic        wb_valid_q, wb_valid_d;
    logic [5:0]  wb_op_q, wb_op_d;
    logic [4:0]  wb_ri_q, wb_ri_d;
    logic        wb_en_q, wb_en_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        br_taken_q, br_taken_d;
    logic [31:0] br_target_q, br_target_d;

    logic access;
    logic timeout;
    logic advance;
    logic ld_mem;

    assign access  = (st_q == StAccess);
    assign timeout = access && !dm_ack && (cnt_q == WaitLast);
    // The timeout cycle releases the pipeline so the aborted op retires on that same edge.
    assign stall_mem = access && !dm_ack && !timeout;
    assign advance   = !stall_mem;
    assign ld_mem    = advance && valid_exi && (op_exi == OpSw || op_exi == OpLw);

    assign dm_req   = access;
    assign dm_we    = access && (op_q == OpSw);
    assign dm_addr  = addr_q;
    assign dm_wdata = alu_q;

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        err_d = err_q;
        unique case (st_q)
            StIdle: begin
                if (ld_mem) begin
                    st_d  = StAccess;
                    cnt_d = 8'd0;
                end
            end
            StAccess: begin
                if (dm_ack || timeout) begin
                    st_d  = ld_mem ? StAccess : StIdle;
                    cnt_d = 8'd0;
                    if (timeout) begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_comb begin
        wb_valid_d  = 1'b0;
        wb_op_d     = 6'd0;
        wb_ri_d     = 5'd0;
        wb_en_d     = 1'b0;
        wb_data_d   = 32'd0;
        br_taken_d  = 1'b0;
        br_target_d = 32'd0;
        if (advance && valid_q) begin
            wb_valid_d = 1'b1;
            wb_op_d    = op_q;
            wb_ri_d    = ri_q;
            if (op_q <= 6'd5) begin
                wb_en_d   = 1'b1;
                wb_data_d = alu_q;
            end else if (op_q == OpLw && access && dm_ack) begin
                wb_en_d   = 1'b1;
                wb_data_d = dm_rdata;
            end
            if ((op_q == OpBeq && ife_q) || op_q == OpJmp) begin
                br_taken_d  = 1'b1;
                br_target_d = addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= StIdle;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            op_q        <= 6'd0;
            ri_q        <= 5'd0;
            ife_q       <= 1'b0;
            alu_q       <= 32'd0;
            addr_q      <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_op_q     <= 6'd0;
            wb_ri_q     <= 5'd0;
            wb_en_q     <= 1'b0;
            wb_data_q   <= 32'd0;
            br_taken_q  <= 1'b0;
            br_target_q <= 32'd0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (advance) begin
                valid_q <= valid_exi;
                op_q    <= op_exi;
                ri_q    <= Ri_exi;
                ife_q   <= ife_exi;
                alu_q   <= alu_exi;
                addr_q  <= addr_exi;
            end
            wb_valid_q  <= wb_valid_d;
            wb_op_q     <= wb_op_d;
            wb_ri_q     <= wb_ri_d;
            wb_en_q     <= wb_en_d;
            wb_data_q   <= wb_data_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    assign valid_memo    = wb_valid_q;
    assign op_memo       = wb_op_q;
    assign Ri_memo       = wb_ri_q;
    assign wb_en_mem     = wb_en_q;
    assign wb_data_mem   = wb_data_q;
    assign br_taken_mem  = br_taken_q;
    assign br_target_mem = br_target_q;
    assign err_mem       = err_q;

endmodule
